// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared encodings and defaults for the multicycle multiply/divide unit
package multdiv_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 5;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {OP_MUL, OP_DIV} op_t;
endpackage

// File: rtl/multdiv_step.sv
// multdiv_step: one combinational shift-add (multiply) or restoring trial-subtract (divide) iteration
module multdiv_step import multdiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   shreg,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   shreg_next
);
    logic [WIDTH:0] sum, shifted, diff;
    // multiply: upper half accumulates, product bits fall into the lower half
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd & {WIDTH{shreg[0]}}};
    // divide: upper half is the partial remainder, quotient bits shift into the lower half
    assign shifted = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
    assign diff = shifted - {1'b0, opnd};
    assign acc_next = !is_div ? {sum, acc[WIDTH-1:1]} :
                      diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                    {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign shreg_next = is_div ? shreg << 1 : shreg >> 1;
endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: fixed-latency signed multiply/divide with busy, ready pulse and destination tag
module multdiv_unit import multdiv_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] tag_in,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    state_t state, state_next;
    op_t op;
    logic neg, start, last, mul_exc, div_exc;
    logic [WIDTH-1:0] opnd, shreg, shreg_next, mag_a, mag_b, quot;
    logic [2*WIDTH-1:0] acc, acc_next, prod;
    logic [CNT_W-1:0] counter;
    logic [TAG_W-1:0] tag_lat;
    assign start = ctrl_MULT | ctrl_DIV;
    assign last = counter == CNT_W'(WIDTH);
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state == IDLE ? (start ? RUN : IDLE) :
                     state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    always_comb begin
        data_resultRDY = state == DONE;
        busy = state != IDLE;
    end
    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div(op == OP_DIV),
        .acc(acc),
        .shreg(shreg),
        .opnd(opnd),
        .acc_next(acc_next),
        .shreg_next(shreg_next)
    );
    // exception: the signed product does not fit, or the quotient is zero-divisor / +2^(WIDTH-1)
    always_comb begin
        prod = neg ? -acc : acc;
        quot = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        mul_exc = !(&prod[2*WIDTH-1:WIDTH-1]) && (|prod[2*WIDTH-1:WIDTH-1]);
        div_exc = ~|opnd | (!neg & acc[WIDTH-1]);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op <= OP_MUL;
            neg <= 1'b0;
            opnd <= '0;
            shreg <= '0;
            acc <= '0;
            counter <= '0;
            tag_lat <= '0;
            data_result <= '0;
            data_exception <= 1'b0;
            tag_out <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                op <= ctrl_MULT ? OP_MUL : OP_DIV;
                neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                opnd <= ctrl_MULT ? mag_a : mag_b;
                shreg <= ctrl_MULT ? mag_b : mag_a;
                acc <= '0;
                counter <= '0;
                tag_lat <= tag_in;
            end
        end else if (state == RUN) begin
            if (!last) begin
                acc <= acc_next;
                shreg <= shreg_next;
                counter <= counter + 1'b1;
            end else begin
                data_result <= op == OP_DIV ? (~|opnd ? '0 : quot) : prod[WIDTH-1:0];
                data_exception <= op == OP_DIV ? div_exc : mul_exc;
                tag_out <= tag_lat;
            end
        end
    end
endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multicycle signed multiply/divide unit in the execute stage, directly downstream of the ALU operand-select logic.
- Consumes the same regfile/immediate-selected operands as the single-cycle ALU when the decoded R-type op is mul (ALU_op 00110) or div (ALU_op 00111).
- Produces a 32-bit result, an exception flag (written to $r30 by writeback) and a one-cycle ready pulse.
- Asserts busy so the hazard logic stalls fetch/decode while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width in bits.
TAG_W, 5, width of destination-register tag carried alongside the operation.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
ctrl_MULT  input  1  start-multiply pulse, sampled at a rising edge.
ctrl_DIV  input  1  start-divide pulse, sampled at a rising edge.
data_operandA  input  WIDTH  signed operand A (multiplicand / dividend).
data_operandB  input  WIDTH  signed operand B (multiplier / divisor).
tag_in  input  TAG_W  destination register of the issuing instruction.
data_result  output  WIDTH  product low word or quotient.
data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY.
data_resultRDY  output  1  one-cycle completion pulse.
tag_out  output  TAG_W  tag latched at start, valid with data_resultRDY.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock/reset: one clock, clock; reset is asynchronous and active-high.
- Reset state: state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, tag_out=0, busy=0, counter=0. Reset mid-operation aborts with no ready pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: at an edge with ctrl_MULT or ctrl_DIV high:
  - Latch the operation, |A|, |B|, sign bits and tag_in.
  - Clear the accumulator and counter.
  - Go to RUN.
  - If both starts are high, MULT wins.
- RUN: one iteration per clock; counter increments. After exactly WIDTH iterations go to DONE.
- DONE: data_resultRDY=1 for exactly this one cycle; data_result, data_exception and tag_out are registered on entry. Next edge returns to IDLE.
- Latency: with the start sampled at edge E0, data_resultRDY is high during the cycle following edge E0+WIDTH+1. Latency is fixed for all operand values, including the exception cases.
- Back-to-back: a start pulse is accepted in the IDLE cycle immediately after DONE. Start pulses while busy=1 are ignored, with no effect on the in-flight operation.
- Output hold: data_result, data_exception and tag_out hold their DONE values until the next DONE or reset.
- Multiply:
  - Unsigned shift-add on the magnitudes into a 2*WIDTH accumulator.
  - At DONE, negate if sign(A)^sign(B).
  - data_result = low WIDTH bits.
  - data_exception = 1 iff the bits [2*WIDTH-1:WIDTH-1] of the signed product are not all equal.
- Divide:
  - Restoring division on the magnitudes, truncating toward zero; the remainder is discarded.
  - Quotient is negated if sign(A)^sign(B).
  - B=0: data_result=0, data_exception=1.
  - A=-2^(WIDTH-1) and B=-1: data_result=0x80000000, data_exception=1.
  - Otherwise data_exception=0.
- Magnitudes are held in WIDTH-bit unsigned registers, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is represented exactly.
- Operand inputs are not required to stay stable after the start edge.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state encoding (IDLE/RUN/DONE);
  - the op encoding (OP_MUL, OP_DIV);
  - the decode constants ALU_MUL=5'b00110 and ALU_DIV=5'b00111, reused by the decode logic;
  - the default WIDTH and TAG_W.
- One sub-module is natural: multdiv_step, a purely combinational single iteration (shift-add for multiply, trial-subtract/restore for divide), instantiated once inside the RUN datapath.

Test Plan:
- Multiply 7 x -6 (A=0x00000007, B=0xFFFFFFFA), start at E0 -> data_resultRDY high only in the cycle after E0+33; data_result=0xFFFFFFD6, exception=0, tag_out=tag_in.
- Multiply overflow: 0x00010000 x 0x00010000 -> data_result=0x00000000, exception=1. Also 0x80000000 x 0x00000001 -> 0x80000000, exception=0.
- Divide -7 / 2 -> 0xFFFFFFFD, exception=0. Then 5 / 0 -> 0x00000000, exception=1 with unchanged latency. Then 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception=1.
- Both starts high with A=3, B=4 -> result 12 (multiply); ctrl_DIV pulsed mid-RUN -> ignored, exactly one ready pulse, busy high E0+1 through DONE.
- Reset asserted asynchronously at iteration 10 -> all outputs 0 immediately, no ready pulse. A new multiply 2 x 3 issued after reset release -> result 6 at nominal latency.
- Back-to-back: start a divide 100/7 in the IDLE cycle right after a multiply's DONE -> first ready shows the product, second shows 14; data_result holds 14 afterwards.
